xgriscv_retire_monitor: RTL and testbench
=========================================

# xgriscv_retire_monitor

Synthesizable end-of-run and liveness monitor for the xgriscv pipeline. It watches the writeback-stage PC stream and counts cycles and retired instructions. It raises a sticky `done` when the program retires its final instruction, `hang` when retirement stalls too long, and `timeout` when a cycle budget is exhausted. It sits beside `xgriscv_pipeline`, driven by the writeback PC (`pcW`), and gives testbenches and on-board debug one stop condition instead of a hard-coded address compare.

## Interface
Parameters:
- `ADDR_W`, 32: width of `pcW` and `last_pc`.
- `END_ADDR`, 32'h80000078: address of the last program instruction.
- `CNT_W`, 32: width of `cycle_cnt` and `retire_cnt`.
- `TIMEOUT_CYCLES`, 100000: RUN cycles before `timeout`; 0 disables the timeout.
- `STALL_LIMIT`, 64: consecutive RUN cycles with no retirement before `hang`; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rstn`  in  1  asynchronous, active-high reset (1 = reset, despite the name).
- `en`  in  1  arms the monitor: IDLE→RUN.
- `clr`  in  1  synchronous return to IDLE; counters and flags cleared.
- `retire_valid`  in  1  `pcW` holds a retiring instruction this cycle.
- `pcW`  in  `ADDR_W`  writeback PC.
- `state`  out  3  IDLE=0, RUN=1, DONE=2, HANG=3, TIMEOUT=4.
- `done`, `hang`, `timeout`  out  1 each  decoded from `state`.
- `stop`  out  1  `done | hang | timeout`.
- `cycle_cnt`  out  `CNT_W`  RUN cycles elapsed.
- `retire_cnt`  out  `CNT_W`  instructions retired in RUN.
- `last_pc`  out  `ADDR_W`  PC of the most recent retirement.

## Operation
- Reset values: `state` = IDLE, all counters 0, `last_pc` 0, all flags 0. Reset asserted mid-run clears everything immediately, without waiting for a clock edge.
- `clr` has top priority after reset: on the edge where `clr` = 1, the block returns to the reset values, regardless of `en`.
- IDLE: counters frozen. `en` = 1 moves to RUN on the next edge. No counting or detection happens in the IDLE cycle.
- RUN, per edge:
  - `cycle_cnt` += 1.
  - If `retire_valid`: `retire_cnt` += 1, `last_pc` ← `pcW`, stall counter ← 0.
  - Otherwise: stall counter += 1.
  - All counters saturate at all-ones and never wrap.
- Terminal conditions, evaluated on the same edge as the count update:
  - DONE: `retire_valid` and `pcW` == `END_ADDR`.
  - HANG: the stall counter reaches `STALL_LIMIT` (the cycle of the STALL_LIMIT-th consecutive non-retiring cycle).
  - TIMEOUT: `cycle_cnt` reaches `TIMEOUT_CYCLES`, with the increment included.
- Priority when conditions coincide: DONE > HANG > TIMEOUT.
- DONE, HANG and TIMEOUT are sticky. Counters and `last_pc` freeze at their values from the transition edge; `en` is ignored; only `clr` or reset leaves a terminal state.
- `en` dropping during RUN does not pause the monitor; RUN continues.
- The count updates on the terminal edge are included: `retire_cnt` counts the END_ADDR instruction.

## Timing
- Flags are decoded from the state register and visible immediately after the edge that sampled the condition. Latency is 1 cycle from input to flag.
- There are no combinational paths from inputs to outputs.
- `cycle_cnt` after DONE equals the number of RUN edges, including the terminal edge.
- There is no handshake: `retire_valid` is sampled every cycle and back-to-back retirements are counted individually.

## Configuration
- `XGRISCV_MON_HANG_EN` defined: stall counter and HANG state are compiled in, as described above.
- Macro undefined:
  - The stall counter is absent and `hang` is tied to 0.
  - State 3 is unreachable.
  - `STALL_LIMIT` is ignored.
  - DONE and TIMEOUT behaviour is unchanged.

## Test plan
- Reset, then `en` = 1, then retire 0x80000000…0x80000078 at one instruction per cycle → `done` = 1 the cycle after 0x80000078 retires, `retire_cnt` = 31, `cycle_cnt` = 31, `last_pc` = 0x80000078.
- RUN with `retire_valid` = 0 for 64 cycles (macro defined) → `hang` = 1 after the 64th edge, `cycle_cnt` = 64. Same stimulus with the macro undefined → `hang` stays 0 and `timeout` fires at `TIMEOUT_CYCLES`.
- `TIMEOUT_CYCLES` = 10, one retirement every cycle at non-end PCs → `timeout` = 1 after 10 edges, `retire_cnt` = 10.
- `STALL_LIMIT` = 1, no retirement on the edge where `cycle_cnt` reaches `TIMEOUT_CYCLES` → `state` = HANG, not TIMEOUT. `END_ADDR` retiring on the `cycle_cnt` = `TIMEOUT_CYCLES` edge → `state` = DONE.
- Assert `rstn` asynchronously mid-RUN at `cycle_cnt` = 5 → all outputs 0 before the next edge. After DONE, pulse `clr` → IDLE with counters 0, then `en` restarts a fresh run.
- `CNT_W` = 4, `TIMEOUT_CYCLES` = 0, `retire_valid` held high at non-end PCs → `cycle_cnt` and `retire_cnt` saturate at 15 and stay there, with no flag asserted.

Source files
------------

// File: rtl/xgriscv_retire_monitor.sv
// End-of-run / liveness monitor for the xgriscv writeback PC stream.
// Define XGRISCV_MON_HANG_EN to build in the stall counter and the HANG state.
module xgriscv_retire_monitor #(
  parameter int unsigned       ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] END_ADDR       = 32'h80000078,
  parameter int unsigned       CNT_W          = 32,
  parameter int unsigned       TIMEOUT_CYCLES = 100000,
  parameter int unsigned       STALL_LIMIT    = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              clr,
  input  logic              retire_valid,
  input  logic [ADDR_W-1:0] pcW,
  output logic [2:0]        state,
  output logic              done,
  output logic              hang,
  output logic              timeout,
  output logic              stop,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [ADDR_W-1:0] last_pc
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DONE    = 3'd2,
    S_HANG    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  if (STALL_LIMIT == 0) begin : g_bad_stall_limit
    $error("STALL_LIMIT must be at least 1");
  end

  // A budget that cannot be represented in CNT_W bits is never reached.
  localparam bit               TO_EN  = (TIMEOUT_CYCLES != 0) && ((TIMEOUT_CYCLES >> CNT_W) == 0);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_retire_cnt;
  logic [ADDR_W-1:0] r_last_pc;

  logic [CNT_W-1:0]  w_cycle_inc;
  logic [CNT_W-1:0]  w_retire_inc;
  logic              w_done_hit;
  logic              w_hang_hit;
  logic              w_to_hit;

  assign w_cycle_inc  = (&r_cycle_cnt)  ? r_cycle_cnt  : r_cycle_cnt  + CNT_W'(1);
  assign w_retire_inc = (&r_retire_cnt) ? r_retire_cnt : r_retire_cnt + CNT_W'(1);
  assign w_done_hit   = retire_valid && (pcW == END_ADDR);
  assign w_to_hit     = TO_EN && (w_cycle_inc == TO_VAL);

`ifdef XGRISCV_MON_HANG_EN
  localparam int unsigned   SW        = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] STALL_VAL = SW'(STALL_LIMIT);

  logic [SW-1:0] r_stall;
  logic [SW-1:0] w_stall_inc;

  assign w_stall_inc = (&r_stall) ? r_stall : r_stall + SW'(1);
  assign w_hang_hit  = !retire_valid && (w_stall_inc == STALL_VAL);
`else
  assign w_hang_hit  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state      <= S_IDLE;
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_last_pc    <= '0;
`ifdef XGRISCV_MON_HANG_EN
      r_stall      <= '0;
`endif
    end else if (clr) begin
      r_state      <= S_IDLE;
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_last_pc    <= '0;
`ifdef XGRISCV_MON_HANG_EN
      r_stall      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) r_state <= S_RUN;
        end
        S_RUN: begin
          r_cycle_cnt <= w_cycle_inc;
          if (retire_valid) begin
            r_retire_cnt <= w_retire_inc;
            r_last_pc    <= pcW;
          end
`ifdef XGRISCV_MON_HANG_EN
          r_stall <= retire_valid ? '0 : w_stall_inc;
`endif
          // Terminal edge still takes the count update above.
          if (w_done_hit)      r_state <= S_DONE;
          else if (w_hang_hit) r_state <= S_HANG;
          else if (w_to_hit)   r_state <= S_TIMEOUT;
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign state      = r_state;
  assign done       = (r_state == S_DONE);
`ifdef XGRISCV_MON_HANG_EN
  assign hang       = (r_state == S_HANG);
`else
  assign hang       = 1'b0;
`endif
  assign timeout    = (r_state == S_TIMEOUT);
  assign stop       = done | hang | timeout;
  assign cycle_cnt  = r_cycle_cnt;
  assign retire_cnt = r_retire_cnt;
  assign last_pc    = r_last_pc;

endmodule

// File: tb/tb_xgriscv_retire_monitor.sv
// Directed bench for xgriscv_retire_monitor; three instances share one stimulus stream.
module tb_xgriscv_retire_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        clr = 1'b0;
  logic        rv  = 1'b0;
  logic [31:0] pc  = '0;

  always #5 clk = ~clk;

  // a: near-default build with a short budget
  logic [2:0]  a_state;
  logic        a_done, a_hang, a_to, a_stop;
  logic [31:0] a_cyc, a_ret, a_pc;
  // b: tiny budget and single-cycle stall limit
  logic [2:0]  b_state;
  logic        b_done, b_hang, b_to, b_stop;
  logic [31:0] b_cyc, b_ret, b_pc;
  // c: 4-bit counters, timeout disabled, unreachable end address
  logic [2:0]  c_state;
  logic        c_done, c_hang, c_to, c_stop;
  logic [3:0]  c_cyc, c_ret;
  logic [31:0] c_pc;

  xgriscv_retire_monitor #(.TIMEOUT_CYCLES(200), .STALL_LIMIT(64)) u_a (
    .clk(clk), .rstn(rst), .en(en), .clr(clr), .retire_valid(rv), .pcW(pc),
    .state(a_state), .done(a_done), .hang(a_hang), .timeout(a_to), .stop(a_stop),
    .cycle_cnt(a_cyc), .retire_cnt(a_ret), .last_pc(a_pc));

  xgriscv_retire_monitor #(.TIMEOUT_CYCLES(10), .STALL_LIMIT(1)) u_b (
    .clk(clk), .rstn(rst), .en(en), .clr(clr), .retire_valid(rv), .pcW(pc),
    .state(b_state), .done(b_done), .hang(b_hang), .timeout(b_to), .stop(b_stop),
    .cycle_cnt(b_cyc), .retire_cnt(b_ret), .last_pc(b_pc));

  xgriscv_retire_monitor #(.END_ADDR(32'h1), .CNT_W(4), .TIMEOUT_CYCLES(0)) u_c (
    .clk(clk), .rstn(rst), .en(en), .clr(clr), .retire_valid(rv), .pcW(pc),
    .state(c_state), .done(c_done), .hang(c_hang), .timeout(c_to), .stop(c_stop),
    .cycle_cnt(c_cyc), .retire_cnt(c_ret), .last_pc(c_pc));

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge; returns on the following falling edge.
  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic restart();
    clr = 1'b1; rv = 1'b0; en = 1'b0;
    step(1);
    clr = 1'b0; en = 1'b1;
    step(1);
    en = 1'b0;
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    step(1);
    check("reset_state", a_state, 3'd0);
    check("reset_cyc", a_cyc, 0);
    check("reset_ret", a_ret, 0);
    check("reset_lastpc", a_pc, 0);
    check("reset_stop", a_stop, 1'b0);

    // Program run to END_ADDR, one retirement per cycle
    en = 1'b1;
    step(1);
    check("arm_state", a_state, 3'd1);
    check("arm_cyc", a_cyc, 0);
    en = 1'b0;
    for (int unsigned i = 0; i < 31; i++) begin
      rv = 1'b1; pc = 32'h80000000 + 32'(4 * i);
      step(1);
    end
    rv = 1'b0;
    check("done_flag", a_done, 1'b1);
    check("done_ret", a_ret, 31);
    check("done_cyc", a_cyc, 31);
    check("done_lastpc", a_pc, 32'h80000078);
    check("done_stop", a_stop, 1'b1);
    check("to10_state", b_state, 3'd4);
    check("to10_ret", b_ret, 10);
    check("to10_cyc", b_cyc, 10);
    check("sat_state", c_state, 3'd1);
    check("sat_cyc", c_cyc, 4'd15);
    check("sat_ret", c_ret, 4'd15);
    check("sat_stop", c_stop, 1'b0);

    // Sticky DONE ignores en and keeps frozen counters
    en = 1'b1; rv = 1'b1; pc = 32'h80000100;
    step(2);
    en = 1'b0; rv = 1'b0;
    check("sticky_state", a_state, 3'd2);
    check("sticky_cyc", a_cyc, 31);
    check("sticky_lastpc", a_pc, 32'h80000078);

    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_state", a_state, 3'd0);
    check("clr_cyc", a_cyc, 0);
    check("clr_ret", a_ret, 0);
    check("clr_lastpc", a_pc, 0);
    step(2);
    check("idle_frozen", a_cyc, 0);

    // No retirement at all
    restart();
    step(64);
`ifdef XGRISCV_MON_HANG_EN
    check("hang_flag", a_hang, 1'b1);
    check("hang_state", a_state, 3'd3);
    check("hang_cyc", a_cyc, 64);
    check("hang_b_state", b_state, 3'd3);
    check("hang_b_cyc", b_cyc, 1);
`else
    check("nohang_flag", a_hang, 1'b0);
    check("nohang_state", a_state, 3'd1);
    step(136);
    check("nohang_to", a_to, 1'b1);
    check("nohang_cyc", a_cyc, 200);
    check("nohang_b_state", b_state, 3'd4);
    check("nohang_b_cyc", b_cyc, 10);
`endif

    // Stall on the budget edge
    restart();
    for (int unsigned i = 0; i < 9; i++) begin
      rv = 1'b1; pc = 32'h80000000 + 32'(4 * i);
      step(1);
    end
    rv = 1'b0;
    step(1);
`ifdef XGRISCV_MON_HANG_EN
    check("prio_hang_state", b_state, 3'd3);
`else
    check("prio_to_state", b_state, 3'd4);
`endif
    check("prio_cyc", b_cyc, 10);
    check("prio_ret", b_ret, 9);

    // END_ADDR retiring on the budget edge
    restart();
    for (int unsigned i = 0; i < 9; i++) begin
      rv = 1'b1; pc = 32'h80000000 + 32'(4 * i);
      step(1);
    end
    pc = 32'h80000078;
    step(1);
    rv = 1'b0;
    check("prio_done_state", b_state, 3'd2);
    check("prio_done_ret", b_ret, 10);
    check("prio_done_cyc", b_cyc, 10);

    // Asynchronous reset mid-run
    restart();
    for (int unsigned i = 0; i < 5; i++) begin
      rv = 1'b1; pc = 32'h80000010 + 32'(4 * i);
      step(1);
    end
    rv = 1'b0;
    check("pre_rst_cyc", a_cyc, 5);
    check("pre_rst_lastpc", a_pc, 32'h80000020);
    rst = 1'b1;
    #1;
    check("arst_state", a_state, 3'd0);
    check("arst_cyc", a_cyc, 0);
    check("arst_ret", a_ret, 0);
    check("arst_lastpc", a_pc, 0);
    check("arst_stop", a_stop, 1'b0);
    step(1);
    rst = 1'b0;

    // Fresh run after reset
    restart();
    rv = 1'b1; pc = 32'h80000040;
    step(1);
    pc = 32'h80000044;
    step(1);
    rv = 1'b0;
    check("fresh_cyc", a_cyc, 2);
    check("fresh_ret", a_ret, 2);
    check("fresh_lastpc", a_pc, 32'h80000044);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
